banked_memory_controller: RTL and testbench

BANKED_MEMORY_CONTROLLER -- requirements
Module: banked_memory_controller

---
 rtl/banked_memory_controller.sv | 141 ++++++++++++++
 tb/tb_banked_memory_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/banked_memory_controller.sv
// Word-addressed memory controller with auto-increment pointer, sweep-to-zero CLEAR and optional
// per-word even parity (enable with `define MEM_PARITY_EN).
module banked_memory_controller #(
    parameter int DATA_W    = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           inst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [DATA_W-1:0]    mem_in,
    output logic [DATA_W-1:0]    data_out,
    output logic                 out_valid,
    output logic [ADDR_BITS-1:0] ptr,
    input  logic                 err_inject,
    output logic                 parity_err,
    output logic                 state_dbg
);
    // Handshake: a request is taken on a rising edge where req_valid and req_ready are both 1;
    // nothing is buffered, so a request not taken on that edge is simply lost.
    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [3:0] OP_WRITE     = 4'h1;
    localparam logic [3:0] OP_READ      = 4'h2;
    localparam logic [3:0] OP_READ_INC  = 4'h3;
    localparam logic [3:0] OP_WRITE_INC = 4'h4;
    localparam logic [3:0] OP_SET_PTR   = 4'h5;
    localparam logic [3:0] OP_CLEAR     = 4'h6;
    localparam logic [3:0] OP_LOAD      = 4'h9;

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   clr_cnt;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic                   accept;
    logic                   wr_en;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [ADDR_BITS-1:0]   rd_addr;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && (state == S_IDLE);
    assign rd_addr   = (inst == OP_READ_INC) ? ptr : addr;
    assign state_dbg = state;

    // The CLEAR sweep owns the write port; user writes are only possible in IDLE.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = data_in;
        if (state == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = '0;
        end else if (accept && inst == OP_WRITE) begin
            wr_en = 1'b1;
        end else if (accept && inst == OP_WRITE_INC) begin
            wr_en   = 1'b1;
            wr_addr = ptr;
        end
    end

    // Storage is deliberately not reset so an aborted CLEAR leaves un-swept words intact.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            data_out  <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            clr_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        case (inst)
                            OP_READ, OP_READ_INC: begin
                                data_out  <= mem[rd_addr];
                                out_valid <= 1'b1;
                                if (inst == OP_READ_INC) ptr <= ptr + 1'b1;
                            end
                            OP_WRITE_INC: ptr <= ptr + 1'b1;
                            OP_SET_PTR:   ptr <= addr;
                            OP_CLEAR: begin
                                state   <= S_CLEAR;
                                clr_cnt <= '0;
                            end
                            OP_LOAD: begin
                                data_out  <= mem_in;
                                out_valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= S_IDLE;
                        ptr   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic wr_par_bad;

    // Injection applies only to user writes; the CLEAR sweep always stores good parity.
    assign wr_par_bad = (state == S_CLEAR) ? 1'b0 : err_inject;

    always_ff @(posedge clock) begin
        if (wr_en) par_mem[wr_addr] <= (^wr_data) ^ wr_par_bad;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if (accept && (inst == OP_READ || inst == OP_READ_INC) &&
                     ((^mem[rd_addr]) != par_mem[rd_addr])) begin
            parity_err <= 1'b1;
        end
    end
`else
    logic unused_err_inject;
    assign unused_err_inject = err_inject;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_banked_memory_controller.sv
// Randomized and directed bench for banked_memory_controller against a transaction-level model.
module tb_banked_memory_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] inst = 4'h0;
    logic [3:0] addr = 4'h0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] mem_in = 8'h00;
    logic [7:0] data_out;
    logic       out_valid;
    logic [3:0] ptr;
    logic       err_inject = 1'b0;
    logic       parity_err;
    logic       state_dbg;

`ifdef MEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    banked_memory_controller #(.DATA_W(8), .ADDR_BITS(4)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .inst(inst), .addr(addr), .data_in(data_in), .mem_in(mem_in),
        .data_out(data_out), .out_valid(out_valid), .ptr(ptr),
        .err_inject(err_inject), .parity_err(parity_err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model and scoreboard
    logic [7:0] m_mem [16];
    bit         m_bad [16];
    int         clear_left = 0;
    logic [3:0] m_ptr = 4'h0;
    logic [7:0] m_dout = 8'h00;
    bit         m_pe = 1'b0;
    logic [7:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver: one clock of stimulus, model update and output checks
    task automatic cycle(input bit v, input logic [3:0] op, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] mi, input bit inj);
        bit         exp_ov;
        logic [7:0] rv;
        int         idx;
        @(negedge clock);
        req_valid = v; inst = op; addr = a; data_in = d; mem_in = mi; err_inject = inj;
        #1 check("req_ready", req_ready, clear_left == 0);
        exp_ov = 1'b0;
        rv     = 8'h00;
        if (clear_left > 0) begin
            idx = 16 - clear_left;
            m_mem[idx] = 8'h00;
            m_bad[idx] = 1'b0;
            clear_left--;
            if (clear_left == 0) m_ptr = 4'h0;
        end else if (v) begin
            case (op)
                4'h1: begin m_mem[a] = d; m_bad[a] = PAR_EN && inj; end
                4'h2: begin rv = m_mem[a]; if (m_bad[a]) m_pe = 1'b1; exp_ov = 1'b1; end
                4'h3: begin
                    rv = m_mem[m_ptr]; if (m_bad[m_ptr]) m_pe = 1'b1; exp_ov = 1'b1;
                    m_ptr = m_ptr + 4'h1;
                end
                4'h4: begin
                    m_mem[m_ptr] = d; m_bad[m_ptr] = PAR_EN && inj;
                    m_ptr = m_ptr + 4'h1;
                end
                4'h5: m_ptr = a;
                4'h6: clear_left = 16;
                4'h9: begin rv = mi; exp_ov = 1'b1; end
                default: ;
            endcase
        end
        if (exp_ov) begin
            exp_q.push_back(rv);
            m_dout = rv;
        end
        @(posedge clock);
        #1;
        check("out_valid", out_valid, exp_ov);
        if (out_valid) begin
            if (exp_q.size() > 0) check("rd_data", data_out, exp_q.pop_front());
            else check("unexpected_out_valid", out_valid, 1'b0);
        end
        check("data_out", data_out, m_dout);
        check("ptr", ptr, m_ptr);
        check("parity_err", parity_err, m_pe);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
    endtask

    // Asynchronous reset pulse applied between clock edges.
    task automatic reset_pulse();
        @(negedge clock);
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        clear_left = 0; m_ptr = 4'h0; m_dout = 8'h00; m_pe = 1'b0;
        exp_q.delete();
        check("rst_data_out", data_out, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_ptr", ptr, 4'h0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] ops [10];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hE, 4'h7, 4'h1};
        for (int i = 0; i < 16; i++) begin m_mem[i] = 8'h00; m_bad[i] = 1'b0; end

        reset_pulse();

        // single write then read-back
        cycle(1'b1, 4'h1, 4'h3, 8'hA5, 8'h00, 1'b0);
        cycle(1'b1, 4'h2, 4'h3, 8'h00, 8'h00, 1'b0);
        check("req032_data", data_out, 8'hA5);

        // pointer wrap with WRITE_INC
        cycle(1'b1, 4'h5, 4'hF, 8'h00, 8'h00, 1'b0);
        cycle(1'b1, 4'h4, 4'h0, 8'h11, 8'h00, 1'b0);
        cycle(1'b1, 4'h4, 4'h0, 8'h22, 8'h00, 1'b0);
        cycle(1'b1, 4'h2, 4'hF, 8'h00, 8'h00, 1'b0);
        check("req033_f", data_out, 8'h11);
        cycle(1'b1, 4'h2, 4'h0, 8'h00, 8'h00, 1'b0);
        check("req033_0", data_out, 8'h22);
        check("req033_ptr", ptr, 4'h1);

        // LOAD, NOP and an undefined opcode
        cycle(1'b1, 4'h9, 4'h0, 8'h00, 8'h3C, 1'b0);
        check("req036_load", data_out, 8'h3C);
        cycle(1'b1, 4'h0, 4'h0, 8'h00, 8'h77, 1'b0);
        cycle(1'b1, 4'hE, 4'h0, 8'h00, 8'h77, 1'b0);

        // fill, then CLEAR with a READ held throughout the sweep
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'h1, 4'(i), 8'hFF, 8'h00, 1'b0);
        cycle(1'b1, 4'h6, 4'h0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'h2, 4'h7, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 4'h2, 4'(i), 8'h00, 8'h00, 1'b0);
            check("req034_zero", data_out, 8'h00);
        end

        // reset five edges into a CLEAR
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'h1, 4'(i), 8'hFF, 8'h00, 1'b0);
        cycle(1'b1, 4'h5, 4'h9, 8'h00, 8'h00, 1'b0);
        cycle(1'b1, 4'h6, 4'h0, 8'h00, 8'h00, 1'b0);
        idle(5);
        reset_pulse();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 4'h2, 4'(i), 8'h00, 8'h00, 1'b0);
            check("req035_word", data_out, (i < 5) ? 8'h00 : 8'hFF);
        end

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 39) == 0) ? 4'h6 : ops[$urandom_range(0, 9)];
            cycle($urandom_range(0, 3) != 0, op, 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 15) == 0);
        end
        idle(17);

        // parity injection and stickiness
        reset_pulse();
        cycle(1'b1, 4'h1, 4'h2, 8'h5A, 8'h00, 1'b1);
        cycle(1'b1, 4'h2, 4'h2, 8'h00, 8'h00, 1'b0);
        check("req037_err", parity_err, PAR_EN);
        cycle(1'b1, 4'h1, 4'h2, 8'h5A, 8'h00, 1'b0);
        cycle(1'b1, 4'h2, 4'h2, 8'h00, 8'h00, 1'b0);
        idle(3);
        check("req037_sticky", parity_err, PAR_EN);
        reset_pulse();
        idle(2);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
